// File: rtl/cpu_host_loader_pkg.sv
// Shared definitions for the host-side memory loader and run controller.
package cpu_host_pkg;

  localparam logic [2:0] OP_WR_I = 3'd0;
  localparam logic [2:0] OP_WR_D = 3'd1;
  localparam logic [2:0] OP_RD_I = 3'd2;
  localparam logic [2:0] OP_RD_D = 3'd3;
  localparam logic [2:0] OP_RUN  = 3'd4;

  localparam logic [63:0] RSP_ZERO = 64'd0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RUN       = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_host_loader_if.sv
// Command/response stream between a host (bench or debug bridge) and the loader.
interface cpu_host_loader_if #(
  parameter int ADDR_W = 64
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [63:0]       cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cpu_host_loader_run_counter.sv
// Cycle-limited run counter: load a limit, count enabled cycles, flag the last one.
module run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [CNT_W-1:0] n_in,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W:0] count_inc;

  // One extra bit keeps the compare exact when the limit is all ones.
  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign last      = (count_inc == {1'b0, limit});

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
      limit <= '0;
    end else if (load) begin
      count <= '0;
      limit <= n_in;
    end else if (en) begin
      count <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/cpu_host_loader.sv
// Host-side initiator: loads/reads imem and dmem ext ports and gates cpu_enable for N cycles.
//  state        | meaning
//  ST_IDLE      | ready for a command
//  ST_WRITE     | one-cycle wen pulse on the selected port
//  ST_READ_REQ  | one-cycle ren pulse on the selected port
//  ST_READ_WAIT | SRAM read data valid, captured into rsp_data
//  ST_RUN       | cpu_enable high until the run counter reaches N
//  ST_RESP      | response held until rsp_ready
module cpu_host_loader
  import cpu_host_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int IMEM_W = 32,
  parameter int DMEM_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              arst,
  cpu_host_loader_if.slave  host,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wen,
  output logic              imem_ren,
  output logic [IMEM_W-1:0] imem_wdata,
  input  logic [IMEM_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wen,
  output logic              dmem_ren,
  output logic [DMEM_W-1:0] dmem_wdata,
  input  logic [DMEM_W-1:0] dmem_rdata,
  output logic              cpu_enable,
  output logic              busy
);

  state_e state_q, state_d;

  logic              sel_dmem_q, sel_dmem_d;
  logic [ADDR_W-1:0] imem_addr_d, dmem_addr_d;
  logic              imem_wen_d, imem_ren_d, dmem_wen_d, dmem_ren_d;
  logic [IMEM_W-1:0] imem_wdata_d;
  logic [DMEM_W-1:0] dmem_wdata_d;
  logic              cpu_enable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0]  cnt_count, cnt_limit, run_n;

  assign run_n = host.cmd_data[CNT_W-1:0];
  assign cnt_en = (state_q == ST_RUN);

  run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk   (clk),
    .arst  (arst),
    .load  (cnt_load),
    .n_in  (run_n),
    .en    (cnt_en),
    .count (cnt_count),
    .limit (cnt_limit),
    .last  (cnt_last)
  );

  assign host.cmd_ready = (state_q == ST_IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;
  assign busy           = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    sel_dmem_d   = sel_dmem_q;
    imem_addr_d  = imem_addr;
    dmem_addr_d  = dmem_addr;
    imem_wdata_d = imem_wdata;
    dmem_wdata_d = dmem_wdata;
    imem_wen_d   = 1'b0;
    imem_ren_d   = 1'b0;
    dmem_wen_d   = 1'b0;
    dmem_ren_d   = 1'b0;
    cpu_enable_d = cpu_enable;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          case (host.cmd_op)
            OP_WR_I: begin
              state_d      = ST_WRITE;
              imem_wen_d   = 1'b1;
              imem_addr_d  = host.cmd_addr;
              imem_wdata_d = host.cmd_data[IMEM_W-1:0];
            end
            OP_WR_D: begin
              state_d      = ST_WRITE;
              dmem_wen_d   = 1'b1;
              dmem_addr_d  = host.cmd_addr;
              dmem_wdata_d = host.cmd_data[DMEM_W-1:0];
            end
            OP_RD_I: begin
              state_d     = ST_READ_REQ;
              sel_dmem_d  = 1'b0;
              imem_ren_d  = 1'b1;
              imem_addr_d = host.cmd_addr;
            end
            OP_RD_D: begin
              state_d     = ST_READ_REQ;
              sel_dmem_d  = 1'b1;
              dmem_ren_d  = 1'b1;
              dmem_addr_d = host.cmd_addr;
            end
            OP_RUN: begin
              cnt_load = 1'b1;
              if (run_n == '0) begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = RSP_ZERO;
              end else begin
                state_d      = ST_RUN;
                cpu_enable_d = 1'b1;
              end
            end
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = RSP_ZERO;
            end
          endcase
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = RSP_ZERO;
      end
      ST_READ_REQ: begin
        state_d = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = sel_dmem_q ? 64'(dmem_rdata) : 64'(imem_rdata);
      end
      ST_RUN: begin
        if (cnt_last) begin
          state_d      = ST_RESP;
          cpu_enable_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = 64'(cnt_limit);
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = RSP_ZERO;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cpu_enable_d = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      sel_dmem_q  <= 1'b0;
      imem_addr   <= '0;
      dmem_addr   <= '0;
      imem_wdata  <= '0;
      dmem_wdata  <= '0;
      imem_wen    <= 1'b0;
      imem_ren    <= 1'b0;
      dmem_wen    <= 1'b0;
      dmem_ren    <= 1'b0;
      cpu_enable  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_dmem_q  <= sel_dmem_d;
      imem_addr   <= imem_addr_d;
      dmem_addr   <= dmem_addr_d;
      imem_wdata  <= imem_wdata_d;
      dmem_wdata  <= dmem_wdata_d;
      imem_wen    <= imem_wen_d;
      imem_ren    <= imem_ren_d;
      dmem_wen    <= dmem_wen_d;
      dmem_ren    <= dmem_ren_d;
      cpu_enable  <= cpu_enable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed, table-driven bench for cpu_host_loader with small imem/dmem SRAM models.
module tb_cpu_host_loader;
  import cpu_host_pkg::*;

  logic        clk;
  logic        arst;
  logic [63:0] imem_addr, dmem_addr;
  logic        imem_wen, imem_ren, dmem_wen, dmem_ren;
  logic [31:0] imem_wdata, imem_rdata;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic        cpu_enable, busy;

  int checks = 0;
  int failures = 0;
  int cnt_wi = 0, cnt_wd = 0, cnt_ri = 0, cnt_rd = 0, cnt_en = 0, prot_viol = 0;

  logic [31:0] imem_m [16];
  logic [63:0] dmem_m [16];

  cpu_host_loader_if #(.ADDR_W(64)) bus ();

  cpu_host_loader #(.CNT_W(32), .IMEM_W(32), .DMEM_W(64), .ADDR_W(64)) dut (
    .clk        (clk),
    .arst       (arst),
    .host       (bus),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_ren   (imem_ren),
    .imem_wdata (imem_wdata),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_ren   (dmem_ren),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .cpu_enable (cpu_enable),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous SRAMs, word index = addr[3:0]
  always @(posedge clk) begin
    if (imem_wen) imem_m[imem_addr[3:0]] <= imem_wdata;
    if (imem_ren) imem_rdata <= imem_m[imem_addr[3:0]];
    if (dmem_wen) dmem_m[dmem_addr[3:0]] <= dmem_wdata;
    if (dmem_ren) dmem_rdata <= dmem_m[dmem_addr[3:0]];
  end

  always @(negedge clk) begin
    if (!arst) begin
      if (imem_wen)   cnt_wi <= cnt_wi + 1;
      if (dmem_wen)   cnt_wd <= cnt_wd + 1;
      if (imem_ren)   cnt_ri <= cnt_ri + 1;
      if (dmem_ren)   cnt_rd <= cnt_rd + 1;
      if (cpu_enable) cnt_en <= cnt_en + 1;
      if ((cpu_enable && (imem_wen || imem_ren || dmem_wen || dmem_ren)) ||
          (imem_wen && imem_ren) || (dmem_wen && dmem_ren) ||
          (cpu_enable && bus.cmd_ready))
        prot_viol <= prot_viol + 1;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [39:0] exp_act;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [39:0] act(input int wi, wd, ri, rd, en);
    return {wi[7:0], wd[7:0], ri[7:0], rd[7:0], en[7:0]};
  endfunction

  function automatic logic [39:0] act_now();
    return act(cnt_wi, cnt_wd, cnt_ri, cnt_rd, cnt_en);
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data,
                        output logic [63:0] r_data, output logic r_err, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    r_data = bus.rsp_data;
    r_err  = bus.rsp_err;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r_data, held;
    logic        r_err;
    logic [39:0] a0;
    int          lat, t, wi0;

    vecs[0]  = '{OP_WR_I, 64'h0, 64'h0000_0000_0050_0093, 64'h0, 1'b0, 2, act(1,0,0,0,0)};
    vecs[1]  = '{OP_WR_D, 64'h8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 2, act(0,1,0,0,0)};
    vecs[2]  = '{OP_RD_D, 64'h8, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3, act(0,0,0,1,0)};
    vecs[3]  = '{OP_WR_I, 64'h4, 64'hFFFF_FFFF_1234_5678, 64'h0, 1'b0, 2, act(1,0,0,0,0)};
    vecs[4]  = '{OP_RD_I, 64'h4, 64'h0, 64'h0000_0000_1234_5678, 1'b0, 3, act(0,0,1,0,0)};
    vecs[5]  = '{OP_RUN,  64'h0, 64'd5, 64'd5, 1'b0, 6, act(0,0,0,0,5)};
    vecs[6]  = '{OP_RUN,  64'h0, 64'd0, 64'd0, 1'b0, 1, act(0,0,0,0,0)};
    vecs[7]  = '{3'd6,    64'h8, 64'h123, 64'h0, 1'b1, 1, act(0,0,0,0,0)};
    vecs[8]  = '{3'd7,    64'h4, 64'h5, 64'h0, 1'b1, 1, act(0,0,0,0,0)};
    vecs[9]  = '{OP_RD_I, 64'h0, 64'h0, 64'h0000_0000_0050_0093, 1'b0, 3, act(0,0,1,0,0)};
    vecs[10] = '{OP_RUN,  64'h0, 64'd1, 64'd1, 1'b0, 2, act(0,0,0,0,1)};
    vecs[11] = '{OP_RUN,  64'h0, 64'hFFFF_FFFF_0000_0003, 64'd3, 1'b0, 4, act(0,0,0,0,3)};
    vecs[12] = '{OP_WR_D, 64'h0, 64'h1, 64'h0, 1'b0, 2, act(0,1,0,0,0)};
    vecs[13] = '{OP_RD_D, 64'h0, 64'h0, 64'h1, 1'b0, 3, act(0,0,0,1,0)};
    vecs[14] = '{OP_RD_D, 64'h8, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3, act(0,0,0,1,0)};

    arst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {63'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, imem_wen, imem_ren, dmem_wen, dmem_ren,
           cpu_enable, busy, (|imem_addr) | (|dmem_addr) | (|imem_wdata) | (|dmem_wdata)},
          {63'd0, 1'b1, 9'd0});
    check("reset_rsp_data", bus.rsp_data, 64'h0);
    arst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      a0 = act_now();
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, r_data, r_err, lat);
      check($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 64'(r_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_activity", i), 64'(act_now() - a0), 64'(vecs[i].exp_act));
    end

    // Response back-pressure: RD_I held 4 cycles while a WR_I waits behind it.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RD_I;
    bus.cmd_addr  = 64'h0;
    bus.cmd_data  = 64'h0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_op   = OP_WR_I;
    bus.cmd_addr = 64'hC;
    bus.cmd_data = 64'h77;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 50);
    check("hold_first_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    held = bus.rsp_data;
    wi0  = cnt_wi;
    check("hold_rsp_data", held, 64'h0050_0093);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("hold_cyc%0d", c), {bus.rsp_valid, bus.cmd_ready, bus.rsp_data},
            {1'b1, 1'b0, held});
    end
    @(posedge clk);
    #1;
    check("hold_no_second_accept", 64'(cnt_wi), 64'(wi0));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_ready_after_handshake", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 50);
    check("hold_second_rsp", {bus.rsp_valid, bus.rsp_data}, {1'b1, 64'h0});
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("hold_second_wen_count", 64'(cnt_wi - wi0), 64'd1);
    do_cmd(OP_RD_I, 64'hC, 64'h0, r_data, r_err, lat);
    check("hold_second_readback", r_data, 64'h77);

    // Reset in the third enabled cycle of RUN N=10.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RUN;
    bus.cmd_data  = 64'd10;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_run_enabled", 64'(cpu_enable), 64'd1);
    #2;
    arst = 1'b1;
    #1;
    check("arst_immediate", {61'd0, cpu_enable, bus.rsp_valid, busy}, 64'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("arst_after_release", {61'd0, bus.cmd_ready, bus.rsp_valid, cpu_enable}, {61'd0, 3'b100});
    do_cmd(OP_RD_D, 64'h8, 64'h0, r_data, r_err, lat);
    check("arst_then_read", r_data, 64'hDEAD_BEEF_CAFE_F00D);

    check("protocol_violations", 64'(prot_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_host_loader.md
Name: cpu_host_loader

Overview:
- Host-side initiator for the core's external memory ports: instruction-memory loader/readback, data-memory loader/readback, and run control.
- Accepts a valid/ready command stream from a testbench or debug bridge. Drives the imem ext port (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext) and the dmem ext port (addr_ext_2/…/rdata_ext_2).
- Gates the core's enable for a commanded number of cycles and returns one response per command.

Parameters:
- CNT_W, 32, width of the run-cycle counter.
- IMEM_W, 32, instruction-memory word width.
- DMEM_W, 64, data-memory word width.
- ADDR_W, 64, external address width.

Ports:
- clk  in  1  main clock
- arst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader accepts command this cycle
- cmd_op  in  3  0=WR_I, 1=WR_D, 2=RD_I, 3=RD_D, 4=RUN, 5..7 illegal
- cmd_addr  in  ADDR_W  memory address (WR/RD ops)
- cmd_data  in  64  write data (WR_I uses [31:0]); RUN: cycle count in [CNT_W-1:0]
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  64  read data, or cycles executed for RUN, or 0
- rsp_err  out  1  illegal opcode
- imem_addr, imem_wen, imem_ren, imem_wdata  out  ADDR_W/1/1/IMEM_W  to cpu addr_ext/wen_ext/ren_ext/wdata_ext
- imem_rdata  in  IMEM_W  from cpu rdata_ext
- dmem_addr, dmem_wen, dmem_ren, dmem_wdata  out  ADDR_W/1/1/DMEM_W  to cpu addr_ext_2/…/wdata_ext_2
- dmem_rdata  in  DMEM_W  from cpu rdata_ext_2
- cpu_enable  out  1  to cpu enable
- busy  out  1  state != IDLE

Behaviour:
- Reset, async on arst high: state=IDLE.
  - cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0.
  - All wen/ren=0; addr/wdata=0; cpu_enable=0; counter=0.
- Handshake:
  - A command is taken on the cycle cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE.
  - The response holds stable while rsp_valid&&!rsp_ready.
  - The next command is accepted the cycle after rsp handshake (IDLE).
- FSM states: IDLE, WRITE, READ_REQ, READ_WAIT, RUN, RESP.
- WR_I / WR_D:
  - IDLE→WRITE. Drives the selected wen=1 for exactly one cycle with addr/wdata registered from the command.
  - WRITE→RESP with rsp_data=0.
- RD_I / RD_D:
  - IDLE→READ_REQ: drives ren=1 and addr for one cycle.
  - READ_WAIT: ren=0; ext read data is valid this cycle (1-cycle synchronous SRAM read). It is captured into rsp_data, zero-extended to 64 for imem.
  - READ_WAIT→RESP.
- RUN with count N:
  - N==0: IDLE→RESP, rsp_data=0; cpu_enable never asserts.
  - N>0: IDLE→RUN. cpu_enable=1 for exactly N consecutive clk cycles, starting the cycle after acceptance.
  - Counter increments each enabled cycle. When counter==N, cpu_enable drops and the FSM goes to RESP with rsp_data=N, zero-extended.
- Exclusivity:
  - No ext wen/ren is asserted while cpu_enable=1.
  - wen and ren are never both high on one port in the same cycle.
- Illegal op: IDLE→RESP with rsp_err=1, rsp_data=0, no memory or enable activity.
- RESP:
  - rsp_valid=1 until rsp_ready.
  - rsp_err clears on leaving RESP.
- Mid-operation reset: arst during RUN drops cpu_enable asynchronously. Any pending response is discarded; state returns to IDLE.
- Counter is CNT_W bits. N=2^CNT_W-1 must run to completion without wrap; the compare uses the registered N.
- All outputs come from registers; there is no combinational path from cmd_* to any memory/enable output.

Decomposition:
- Shared package cpu_host_pkg: opcode constants OP_WR_I..OP_RUN, state enum encoding, response-zero constant.
- One sub-module: run_counter (load N, count, done flag), reused for cycle-limited runs elsewhere.
- Reuse existing reg_arstn_en is not possible (opposite reset polarity). Registers are local.

Test Plan:
- WR_I addr=0x0 data=0x00500093 → one cycle imem_wen=1, imem_addr=0, imem_wdata=0x00500093; rsp_valid, rsp_data=0, rsp_err=0.
- WR_D addr=0x8 data=0xDEADBEEF_CAFEF00D then RD_D addr=0x8 → dmem_ren pulse, rsp_data=0xDEADBEEFCAFEF00D two cycles after acceptance.
- RUN N=5 → cpu_enable high exactly 5 cycles, cmd_ready=0 throughout, rsp_data=5. RUN N=0 → no enable pulse, rsp_data=0.
- cmd_op=6 → rsp_err=1, rsp_data=0; no wen/ren/enable toggles.
- rsp_ready held low 4 cycles after RD_I → rsp_valid and rsp_data stable, second command not accepted until handshake.
- arst asserted at 3rd cycle of RUN N=10 → cpu_enable=0 immediately (same cycle), rsp_valid=0, cmd_ready=1 after release.
